// File: rtl/store_buffer_lsu.sv
// rtl/store_buffer_lsu.sv - store buffer and load path in front of the MEM-stage data memory
// Optional store-to-load forwarding is compiled in with `define STORE_FORWARD_EN.
module store_buffer_lsu #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic [1:0]               st_size,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  input  logic [1:0]               ld_size,
  input  logic                     ld_signed,
  output logic [DW-1:0]            ld_data,
  output logic                     ld_stall,
  output logic [AW-1:0]            mem_adr,
  output logic [DW-1:0]            mem_datain,
  output logic                     mem_w,
  output logic                     mem_r,
  input  logic [DW-1:0]            mem_dataout,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    e_addr [DEPTH];
  logic [DW-1:0]    e_data [DEPTH];
  logic [1:0]       e_size [DEPTH];
  logic [DEPTH-1:0] e_valid;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [AW-1:0]    last_adr;

  logic [DEPTH-1:0] hit_vec;
  logic             any_hit, accept, do_load, do_drain, fwd_ok;
  logic [DW-1:0]    fwd_data;

  function automatic logic [AW-1:0] nbytes(input logic [1:0] sz);
    nbytes = AW'(1) << sz;
  endfunction

  function automatic logic [DW-1:0] extend(input logic [DW-1:0] d, input logic [1:0] sz, input logic sg);
    case (sz)
      2'b00:   extend = {{56{sg & d[7]}},  d[7:0]};
      2'b01:   extend = {{48{sg & d[15]}}, d[15:0]};
      2'b10:   extend = {{32{sg & d[31]}}, d[31:0]};
      default: extend = d;
    endcase
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] m, input logic [DW-1:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   merge = {m[63:8],  d[7:0]};
      2'b01:   merge = {m[63:16], d[15:0]};
      2'b10:   merge = {m[63:32], d[31:0]};
      default: merge = d;
    endcase
  endfunction

  assign st_ready = (count < CW'(DEPTH));
  assign sb_empty = (count == '0);
  assign sb_count = count;
  assign accept   = st_valid && st_ready;

  // Byte-range overlap of the load against every entry valid at the start of the cycle.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = e_valid[i] &&
                   (ld_addr < e_addr[i] + nbytes(e_size[i])) &&
                   (e_addr[i] < ld_addr + nbytes(ld_size));
    end
  end
  assign any_hit = ld_valid && (|hit_vec);

`ifdef STORE_FORWARD_EN
  logic [PW-1:0] fwd_idx;
  // Forwarding needs exactly one overlapping entry, which is then also the youngest one.
  always_comb begin
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_vec[i]) fwd_idx = PW'(i);
    end
  end
  assign fwd_ok   = any_hit && $onehot(hit_vec) &&
                    (e_addr[fwd_idx] == ld_addr) && (e_size[fwd_idx] >= ld_size);
  assign fwd_data = e_data[fwd_idx];
`else
  assign fwd_ok   = 1'b0;
  assign fwd_data = '0;
`endif

  // Memory port arbitration: a clean load wins, otherwise drain the oldest entry.
  always_comb begin
    do_load    = 1'b0;
    do_drain   = 1'b0;
    ld_stall   = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    mem_adr    = last_adr;
    mem_datain = '0;
    if (!rst) begin
      do_load  = ld_valid && !st_valid && !any_hit;
      do_drain = (count != '0) && (!ld_valid || any_hit);
      ld_stall = ld_valid && (st_valid || (any_hit && !fwd_ok));
      if (do_load) begin
        mem_r   = 1'b1;
        mem_adr = ld_addr;
      end else if (do_drain) begin
        mem_r      = 1'b1;
        mem_w      = 1'b1;
        mem_adr    = e_addr[rd_ptr];
        mem_datain = merge(mem_dataout, e_data[rd_ptr], e_size[rd_ptr]);
      end
    end
  end

  // Load result: size-extracted and extended, zero whenever the load does not complete.
  always_comb begin
    ld_data = '0;
    if (!rst && ld_valid && !ld_stall) begin
      ld_data = fwd_ok ? extend(fwd_data, ld_size, ld_signed)
                       : extend(mem_dataout, ld_size, ld_signed);
    end
  end

  // Buffer state: pointers, occupancy, entry payload and the held memory address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      e_valid  <= '0;
      last_adr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
        e_size[i] <= '0;
      end
    end else begin
      last_adr <= mem_adr;
      if (accept) begin
        e_valid[wr_ptr] <= 1'b1;
        e_addr[wr_ptr]  <= st_addr;
        e_data[wr_ptr]  <= st_data;
        e_size[wr_ptr]  <= st_size;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (do_drain) begin
        e_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      case ({accept, do_drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
